// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard controller: opcodes, FSM
// encoding, forward-select codes and small decode helpers.
package ex_hazard_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FW_NONE = 2'b00,
        FW_ALL  = 2'b01,
        FW_Z    = 2'b10
    } flag_wr_t;

    // Which part of {Z,V,N} an EX opcode updates.
    function automatic flag_wr_t flag_write(input logic [3:0] op);
        flag_wr_t fw;
        fw = FW_NONE;
        if (op == OP_ADD || op == OP_SUB)
            fw = FW_ALL;
        else if (op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR)
            fw = FW_Z;
        return fw;
    endfunction

    // MEM beats WB; R0 is hardwired so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                           input logic [3:0] mem_rd,
                                           input logic       mem_we,
                                           input logic [3:0] wb_rd,
                                           input logic       wb_we);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_we && mem_rd != 4'd0 && mem_rd == src)
            sel = FWD_MEM;
        else if (wb_we && wb_rd != 4'd0 && wb_rd == src)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_br_cond.sv
// Branch condition evaluator: condition code against the {Z,V,N} flags.
module br_cond
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;

    assign z = flags[2];
    assign v = flags[1];
    assign n = flags[0];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            3'b000: taken = !z;
            3'b001: taken = z;
            3'b010: taken = !z && !n;
            3'b011: taken = n;
            3'b100: taken = z || !n;
            3'b101: taken = n || z;
            3'b110: taken = v;
            3'b111: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: operand forwarding, stall sequencing, flag
// register, branch resolution in ID and halt handling.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_opcode,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic [1:0] id_src_en,
    input  logic [2:0] id_ccc,
    input  logic [3:0] ex_opcode,
    input  logic       ex_valid,
    input  logic [3:0] ex_rs,
    input  logic [3:0] ex_rt,
    input  logic [3:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic [2:0] ex_flags,
    input  logic [3:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic       mem_memread,
    input  logic [3:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       fwd_br,
    output logic       stall,
    output logic       flush,
    output logic       br_taken,
    output logic [2:0] flags,
    output logic       halted
);

    state_t     state_reg, state_next;
    logic [1:0] stall_cnt_reg, stall_cnt_next;
    logic [2:0] flags_reg;
    logic       cond_true;
    logic       id_is_branch, ex_is_lw;
    logic       load_use, flag_haz, br_ex_haz, br_mem_haz;
    logic [1:0] need;
    logic       stall_int, branch_int;

    assign fwd_a  = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_b  = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_br = mem_regwrite && !mem_memread && id_rs != 4'd0 && mem_rd == id_rs;

    br_cond u_br_cond (
        .ccc   (id_ccc),
        .flags (flags_reg),
        .taken (cond_true)
    );

    assign id_is_branch = (id_opcode == OP_B) || (id_opcode == OP_BR);
    assign ex_is_lw     = ex_valid && (ex_opcode == OP_LW);

    assign load_use = ex_is_lw && ex_rd != 4'd0 &&
                      ((id_src_en[1] && id_rs == ex_rd) || (id_src_en[0] && id_rt == ex_rd));
    assign flag_haz = id_is_branch && ex_valid && (flag_write(ex_opcode) != FW_NONE);
    // BR reads its target register in ID, so only a MEM ALU result can be forwarded.
    assign br_ex_haz  = (id_opcode == OP_BR) && id_rs != 4'd0 &&
                        ex_valid && ex_regwrite && ex_rd == id_rs;
    assign br_mem_haz = (id_opcode == OP_BR) && id_rs != 4'd0 &&
                        mem_regwrite && mem_memread && mem_rd == id_rs;

    always_comb begin
        need = 2'd0;
        if (load_use || flag_haz || br_ex_haz || br_mem_haz)
            need = 2'd1;
        if (br_ex_haz && ex_is_lw)
            need = 2'd2;
    end

    always_comb begin
        state_next     = state_reg;
        stall_cnt_next = stall_cnt_reg;
        stall_int      = 1'b0;
        branch_int     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (need != 2'd0) begin
                    stall_int      = 1'b1;
                    stall_cnt_next = need - 2'd1;
                    if (need != 2'd1)
                        state_next = ST_STALL;
                end else begin
                    branch_int = id_is_branch && cond_true;
                    if (id_opcode == OP_HLT)
                        state_next = ST_HALT;
                end
            end
            ST_STALL: begin
                stall_int      = 1'b1;
                stall_cnt_next = stall_cnt_reg - 2'd1;
                if (stall_cnt_reg <= 2'd1)
                    state_next = ST_RUN;
            end
            ST_HALT: begin
                stall_int = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            stall_cnt_reg <= 2'd0;
            flags_reg     <= 3'b000;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
            if (ex_valid) begin
                case (flag_write(ex_opcode))
                    FW_ALL:  flags_reg    <= ex_flags;
                    FW_Z:    flags_reg[2] <= ex_flags[2];
                    default: flags_reg    <= flags_reg;
                endcase
            end
        end
    end

    assign stall    = rst_n && stall_int;
    assign br_taken = rst_n && branch_int;
    assign flush    = br_taken;
    assign flags    = flags_reg;
    assign halted   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed pipeline scenarios then
// random traffic, checked against a cycle-level behavioural model.
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_opcode, id_rs, id_rt;
    logic [1:0] id_src_en;
    logic [2:0] id_ccc;
    logic [3:0] ex_opcode, ex_rs, ex_rt, ex_rd;
    logic       ex_valid, ex_regwrite;
    logic [2:0] ex_flags;
    logic [3:0] mem_rd, wb_rd;
    logic       mem_regwrite, mem_memread, wb_regwrite;
    logic [1:0] fwd_a, fwd_b;
    logic       fwd_br, stall, flush, br_taken, halted;
    logic [2:0] flags;

    ex_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_src_en(id_src_en), .id_ccc(id_ccc),
        .ex_opcode(ex_opcode), .ex_valid(ex_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_flags(ex_flags),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_br(fwd_br),
        .stall(stall), .flush(flush), .br_taken(br_taken),
        .flags(flags), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       fbr;
        logic       st;
        logic       fl;
        logic       bt;
        logic [2:0] flags;
        logic       halted;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Model state: extra stall cycles still owed, halt latch, flag register.
    int         m_left;
    bit         m_halted;
    logic [2:0] m_flags;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fwd",    {3'b0, fwd_a, fwd_b, fwd_br},    {3'b0, e.fa, e.fb, e.fbr});
                chk("ctrl",   {5'b0, stall, flush, br_taken},  {5'b0, e.st, e.fl, e.bt});
                chk("flags",  {5'b0, flags},                    {5'b0, e.flags});
                chk("halted", {7'b0, halted},                   {7'b0, e.halted});
                $display("cyc=%0d fa=%0d fb=%0d fbr=%0b stall=%0b br=%0b flags=%b halted=%0b",
                         cyc, fwd_a, fwd_b, fwd_br, stall, br_taken, flags, halted);
                cyc++;
            end
        end
    end

    function automatic logic [1:0] m_fsel(input logic [3:0] src);
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'd1;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_cond(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int m_need();
        int n;
        bit flagw;
        n = 0;
        flagw = ex_opcode inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
        if (ex_valid && ex_opcode == 4'h8 && ex_rd != 0 &&
            ((id_src_en[1] && id_rs == ex_rd) || (id_src_en[0] && id_rt == ex_rd)))
            n = 1;
        if ((id_opcode == 4'hC || id_opcode == 4'hD) && ex_valid && flagw)
            n = 1;
        if (id_opcode == 4'hD && id_rs != 0) begin
            if (ex_valid && ex_regwrite && ex_rd == id_rs)
                n = (ex_opcode == 4'h8) ? 2 : ((n > 1) ? n : 1);
            if (mem_regwrite && mem_memread && mem_rd == id_rs && n < 1)
                n = 1;
        end
        return n;
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model past the edge.
    task automatic cycle();
        exp_t e;
        int need, n_left;
        bit n_halt;
        logic [2:0] nf;
        e.fa = m_fsel(ex_rs);
        e.fb = m_fsel(ex_rt);
        e.fbr = mem_regwrite && !mem_memread && id_rs != 0 && mem_rd == id_rs;
        e.flags = m_flags;
        e.halted = m_halted;
        e.st = 1'b0;
        e.bt = 1'b0;
        n_left = m_left;
        n_halt = m_halted;
        nf = m_flags;
        if (!rst_n) begin
            n_left = 0; n_halt = 0; nf = 3'b000;
        end else begin
            if (m_halted) begin
                e.st = 1'b1;
            end else if (m_left > 0) begin
                e.st = 1'b1;
                n_left = m_left - 1;
            end else begin
                need = m_need();
                if (need > 0) begin
                    e.st = 1'b1;
                    n_left = need - 1;
                end else begin
                    e.bt = (id_opcode == 4'hC || id_opcode == 4'hD) && m_cond(id_ccc, m_flags);
                    if (id_opcode == 4'hF) n_halt = 1;
                end
            end
            if (ex_valid) begin
                if (ex_opcode inside {4'h0, 4'h1}) nf = ex_flags;
                else if (ex_opcode inside {4'h2, 4'h4, 4'h5, 4'h6}) nf[2] = ex_flags[2];
            end
        end
        e.fl = e.bt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        m_left = n_left; m_halted = n_halt; m_flags = nf;
    endtask

    task automatic idle();
        rst_n = 1; id_opcode = 4'h3; id_rs = 0; id_rt = 0; id_src_en = 0; id_ccc = 0;
        ex_opcode = 0; ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0;
        ex_flags = 0; mem_rd = 0; mem_regwrite = 0; mem_memread = 0; wb_rd = 0; wb_regwrite = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        m_left = 0; m_halted = 0; m_flags = 3'b000;
        cycle();                                   // reset state observed

        // MEM beats WB; R0 never forwards
        idle(); mem_regwrite = 1; mem_rd = 1; wb_regwrite = 1; wb_rd = 1; ex_rs = 1; cycle();
        mem_rd = 0; wb_rd = 0; ex_rs = 0; cycle();

        // Load-use: one bubble then WB forward
        idle(); ex_valid = 1; ex_opcode = 4'h8; ex_rd = 3; ex_regwrite = 1;
        id_opcode = 4'h0; id_rs = 3; id_src_en = 2'b10; cycle();
        ex_valid = 0; mem_rd = 3; mem_regwrite = 1; mem_memread = 1; cycle();
        idle(); ex_valid = 1; ex_opcode = 4'h0; ex_rs = 3; ex_rd = 5; ex_regwrite = 1;
        wb_rd = 3; wb_regwrite = 1; cycle();

        // Flag hazard on B after SUB producing zero
        idle(); ex_valid = 1; ex_opcode = 4'h1; ex_flags = 3'b100; ex_regwrite = 1; ex_rd = 2;
        id_opcode = 4'hC; id_ccc = 3'b001; cycle();
        ex_valid = 0; cycle();
        id_opcode = 4'h3; cycle();

        // BR behind LW: two stall cycles, no fwd_br
        idle(); ex_valid = 1; ex_opcode = 4'h8; ex_rd = 4; ex_regwrite = 1;
        id_opcode = 4'hD; id_rs = 4; id_src_en = 2'b10; id_ccc = 3'b111; cycle();
        ex_valid = 0; mem_rd = 4; mem_regwrite = 1; mem_memread = 1; cycle();
        mem_rd = 0; mem_regwrite = 0; mem_memread = 0; wb_rd = 4; wb_regwrite = 1; cycle();
        id_opcode = 4'h3; cycle();

        // V held across a Z-only writer
        idle(); ex_valid = 1; ex_opcode = 4'h0; ex_flags = 3'b010; cycle();
        ex_opcode = 4'h2; ex_flags = 3'b100; cycle();
        ex_valid = 0; id_opcode = 4'hC; id_ccc = 3'b110; cycle();

        // Halt persists until reset
        idle(); id_opcode = 4'hF; cycle();
        id_opcode = 4'h0;
        for (int i = 0; i < 10; i++) cycle();
        rst_n = 0; cycle();
        rst_n = 1; cycle();

        // Randomised traffic with occasional resets and halts
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(0, 39) != 0);
            id_opcode   = 4'($urandom_range(0, 15));
            if (id_opcode == 4'hF && $urandom_range(0, 9) != 0) id_opcode = 4'hD;
            if ($urandom_range(0, 2) == 0) id_opcode = ($urandom_range(0, 1) != 0) ? 4'hC : 4'hD;
            id_rs       = 4'($urandom_range(0, 3));
            id_rt       = 4'($urandom_range(0, 3));
            id_src_en   = 2'($urandom_range(0, 3));
            id_ccc      = 3'($urandom_range(0, 7));
            ex_opcode   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ex_opcode = 4'h8;
            ex_valid    = 1'($urandom_range(0, 1));
            ex_rs       = 4'($urandom_range(0, 3));
            ex_rt       = 4'($urandom_range(0, 3));
            ex_rd       = 4'($urandom_range(0, 3));
            ex_regwrite = 1'($urandom_range(0, 1));
            ex_flags    = 3'($urandom_range(0, 7));
            mem_rd      = 4'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_memread = 1'($urandom_range(0, 1));
            wb_rd       = 4'($urandom_range(0, 3));
            wb_regwrite = 1'($urandom_range(0, 1));
            cycle();
        end

        idle();
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
